// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU for the CPU execute stage.
//
// Single-cycle operations register their result on the accept edge. MUL is
// an unsigned shift-add and DIV/REM an unsigned restoring divider; each takes
// XLEN iterations, one per clock. One operation is in flight at a time, and
// the result is held until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   opcode/operands valid        in_ready   ALU can accept (IDLE only)
//   opcode     8-bit operation select       operand1/2 XLEN-bit operands
//   out_valid  result valid                 out_ready  consumer takes result
//   result     XLEN-bit result, frozen while out_valid && !out_ready
//   div_zero   DIV/REM with operand2 == 0   illegal    opcode > 13
module alu_mc #(
   parameter int XLEN      = 64,
   parameter int SHAMT_W   = $clog2(XLEN),
   parameter int LUI_SHIFT = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [7:0]      opcode,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_zero,
   output logic            illegal
);

   localparam logic [7:0] OP_ADD  = 8'd0;
   localparam logic [7:0] OP_ADDI = 8'd1;
   localparam logic [7:0] OP_SUB  = 8'd2;
   localparam logic [7:0] OP_MUL  = 8'd3;
   localparam logic [7:0] OP_DIV  = 8'd4;
   localparam logic [7:0] OP_SLL  = 8'd5;
   localparam logic [7:0] OP_SRL  = 8'd6;
   localparam logic [7:0] OP_AND  = 8'd7;
   localparam logic [7:0] OP_OR   = 8'd8;
   localparam logic [7:0] OP_NOT  = 8'd9;
   localparam logic [7:0] OP_XOR  = 8'd10;
   localparam logic [7:0] OP_LUI  = 8'd11;
   localparam logic [7:0] OP_SRA  = 8'd12;
   localparam logic [7:0] OP_REM  = 8'd13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t state;

   // Iteration registers, shared by MUL and DIV:
   //   MUL: opa = multiplicand (shifts left), opb = multiplier (shifts right),
   //        acc = partial product.
   //   DIV: opa = dividend shifting out / quotient shifting in,
   //        opb = divisor, acc = partial remainder.
   logic [XLEN-1:0]    opa;
   logic [XLEN-1:0]    opb;
   logic [XLEN-1:0]    acc;
   logic [SHAMT_W-1:0] cnt;
   logic               is_rem;

   logic               is_divrem;
   logic [XLEN-1:0]    alu_res;
   logic [XLEN-1:0]    mul_acc_next;
   logic [XLEN-1:0]    div_shift;
   logic               div_ge;
   logic [XLEN-1:0]    div_rem_next;
   logic [XLEN-1:0]    div_quo_next;

   assign is_divrem = (opcode == OP_DIV) || (opcode == OP_REM);

   // Single-cycle result, taken straight from the inputs on the accept edge.
   // DIV/REM only reach this path when the divisor is zero.
   always_comb begin
      logic [SHAMT_W-1:0] shamt;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      alu_res = '0;
      shamt   = operand2[SHAMT_W-1:0];
      case (opcode)
         OP_ADD, OP_ADDI: alu_res = operand1 + operand2;
         OP_SUB:          alu_res = operand1 - operand2;
         OP_AND:          alu_res = operand1 & operand2;
         OP_OR:           alu_res = operand1 | operand2;
         OP_XOR:          alu_res = operand1 ^ operand2;
         OP_NOT:          alu_res = ~operand1;
         OP_SLL:          alu_res = operand1 << shamt;
         OP_SRL:          alu_res = operand1 >> shamt;
         OP_SRA:          alu_res = $signed(operand1) >>> shamt;
         OP_LUI:          alu_res = operand2 << LUI_SHIFT;
         OP_DIV:          alu_res = '1;
         OP_REM:          alu_res = operand1;
         default:         alu_res = '0;
      endcase
   end

   // One shift-add step.
   assign mul_acc_next = opb[0] ? (acc + opa) : acc;

   // One restoring-division step. The bit shifted out of acc is kept aside
   // as the carry: if it is set, the shifted remainder is at least 2^XLEN
   // and therefore exceeds any divisor. The subtraction is modulo 2^XLEN,
   // which is exact because the true difference is below the divisor.
   assign div_shift    = {acc[XLEN-2:0], opa[XLEN-1]};
   assign div_ge       = acc[XLEN-1] || (div_shift >= opb);
   assign div_rem_next = div_ge ? (div_shift - opb) : div_shift;
   assign div_quo_next = {opa[XLEN-2:0], div_ge};

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the iteration registers are reset too; that keeps them out
         // of X after reset and costs nothing at this size.
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
         cnt       <= '0;
         is_rem    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  div_zero <= 1'b0;
                  illegal  <= 1'b0;
                  is_rem   <= (opcode == OP_REM);
                  if (opcode == OP_MUL) begin
                     opa   <= operand1;
                     opb   <= operand2;
                     acc   <= '0;
                     cnt   <= '1;  // XLEN-1, since XLEN is a power of 2
                     state <= S_MUL;
                  end else if (is_divrem && (operand2 != '0)) begin
                     opa   <= operand1;
                     opb   <= operand2;
                     acc   <= '0;
                     cnt   <= '1;
                     state <= S_DIV;
                  end else begin
                     // Reaching here with DIV/REM means the divisor is zero.
                     result    <= alu_res;
                     div_zero  <= is_divrem;
                     illegal   <= (opcode > OP_REM);
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end

            S_MUL: begin
               acc <= mul_acc_next;
               opa <= opa << 1;
               opb <= opb >> 1;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result    <= mul_acc_next;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end

            S_DIV: begin
               acc <= div_rem_next;
               opa <= div_quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result    <= is_rem ? div_rem_next : div_quo_next;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- directed test of alu_mc at XLEN=64 and XLEN=32.
// Two instances share clock, reset, opcode/operands and out_ready; each has
// its own in_valid, so only one is driven at a time. Outputs are sampled on
// the falling edge.
module tb_alu_mc;

   localparam logic [7:0] OP_ADD = 8'd0;
   localparam logic [7:0] OP_SUB = 8'd2;
   localparam logic [7:0] OP_MUL = 8'd3;
   localparam logic [7:0] OP_DIV = 8'd4;
   localparam logic [7:0] OP_LUI = 8'd11;
   localparam logic [7:0] OP_SRA = 8'd12;
   localparam logic [7:0] OP_REM = 8'd13;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  opcode;
   logic [63:0] op1;
   logic [63:0] op2;
   logic        out_ready;
   logic        v64;
   logic        v32;

   logic        ir64, ov64, dz64, il64;
   logic [63:0] r64;
   logic        ir32, ov32, dz32, il32;
   logic [31:0] r32;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_mc #(.XLEN(64)) dut64 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v64),
      .in_ready  (ir64),
      .opcode    (opcode),
      .operand1  (op1),
      .operand2  (op2),
      .out_valid (ov64),
      .out_ready (out_ready),
      .result    (r64),
      .div_zero  (dz64),
      .illegal   (il64)
   );

   alu_mc #(.XLEN(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v32),
      .in_ready  (ir32),
      .opcode    (opcode),
      .operand1  (op1[31:0]),
      .operand2  (op2[31:0]),
      .out_valid (ov32),
      .out_ready (out_ready),
      .result    (r32),
      .div_zero  (dz32),
      .illegal   (il32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic get_ir(input bit n32);
      return n32 ? ir32 : ir64;
   endfunction

   function automatic logic get_ov(input bit n32);
      return n32 ? ov32 : ov64;
   endfunction

   function automatic logic [63:0] get_r(input bit n32);
      return n32 ? {32'h0, r32} : r64;
   endfunction

   function automatic logic get_dz(input bit n32);
      return n32 ? dz32 : dz64;
   endfunction

   function automatic logic get_il(input bit n32);
      return n32 ? il32 : il64;
   endfunction

   // Issue one operation and collect its result. lat = falling edges from
   // the accept edge until out_valid is first seen (1 = single-cycle).
   // rlow = falling edges with in_ready low. hold = cycles of out_ready=0
   // after the result appears. Operands are scrambled right after accept.
   task automatic do_op(input string tag, input bit n32, input logic [7:0] opc,
                        input logic [63:0] a, input logic [63:0] b, input int hold,
                        output logic [63:0] r, output logic dz, output logic il,
                        output int lat, output int rlow);
      bit seen;
      @(negedge clk);
      opcode    = opc;
      op1       = a;
      op2       = b;
      out_ready = (hold == 0);
      if (n32) v32 = 1'b1;
      else     v64 = 1'b1;
      @(posedge clk);
      #1;
      v64    = 1'b0;
      v32    = 1'b0;
      op1    = ~a;
      op2    = ~b;
      opcode = 8'h07;
      lat    = 0;
      rlow   = 0;
      seen   = 1'b0;
      r      = '0;
      dz     = 1'b0;
      il     = 1'b0;
      while (!seen && lat < 200) begin
         @(negedge clk);
         lat++;
         if (!get_ir(n32)) rlow++;
         if (get_ov(n32)) seen = 1'b1;
      end
      check({tag, "_out_valid_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         r  = get_r(n32);
         dz = get_dz(n32);
         il = get_il(n32);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!get_ir(n32)) rlow++;
            check({tag, "_held_result"}, get_r(n32), r);
            check({tag, "_held_valid"}, 64'(get_ov(n32)), 64'd1);
            check({tag, "_held_in_ready"}, 64'(get_ir(n32)), 64'd0);
         end
         out_ready = 1'b1;
         @(negedge clk);
         check({tag, "_taken_in_ready"}, 64'(get_ir(n32)), 64'd1);
         check({tag, "_taken_out_valid"}, 64'(get_ov(n32)), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] r;
      logic        dz, il;
      int          lat, rlow;

      rst = 1'b1; v64 = 1'b0; v32 = 1'b0; out_ready = 1'b0;
      opcode = '0; op1 = '0; op2 = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(ir64), 64'd1);
      check("rst_out_valid", 64'(ov64), 64'd0);
      check("rst_result", r64, 64'd0);
      check("rst_flags", {62'd0, dz64, il64}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(ir64), 64'd1);
      check("post_rst_in_ready32", 64'(ir32), 64'd1);

      // 1. ADD wraps.
      do_op("add_wrap", 1'b0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, r, dz, il, lat, rlow);
      check("add_wrap_result", r, 64'd0);
      check("add_wrap_flags", {62'd0, dz, il}, 64'd0);
      check("add_wrap_latency", 64'(lat), 64'd1);

      // 2. MUL.
      do_op("mul", 1'b0, OP_MUL, 64'h1_0000_0003, 64'h5, 0, r, dz, il, lat, rlow);
      check("mul_result", r, 64'h5_0000_000F);
      check("mul_latency", 64'(lat), 64'd65);
      check("mul_in_ready_low", 64'(rlow), 64'd65);

      // 3. DIV / REM / divide by zero; flags clear on the following accept.
      do_op("div", 1'b0, OP_DIV, 64'd100, 64'd7, 0, r, dz, il, lat, rlow);
      check("div_result", r, 64'd14);
      check("div_latency", 64'(lat), 64'd65);
      do_op("div0", 1'b0, OP_DIV, 64'd5, 64'd0, 0, r, dz, il, lat, rlow);
      check("div0_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div0_flag", 64'(dz), 64'd1);
      check("div0_latency", 64'(lat), 64'd1);
      do_op("rem", 1'b0, OP_REM, 64'd100, 64'd7, 0, r, dz, il, lat, rlow);
      check("rem_result", r, 64'd2);
      check("rem_flag_cleared", 64'(dz), 64'd0);
      do_op("rem0", 1'b0, OP_REM, 64'd5, 64'd0, 0, r, dz, il, lat, rlow);
      check("rem0_result", r, 64'd5);
      check("rem0_flag", 64'(dz), 64'd1);
      do_op("div_big", 1'b0, OP_DIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0,
            r, dz, il, lat, rlow);
      check("div_big_result", r, 64'd1);

      // 4. SRA uses only the low shift bits; LUI.
      do_op("sra", 1'b0, OP_SRA, 64'h8000_0000_0000_0000, 64'h41, 0, r, dz, il, lat, rlow);
      check("sra_result", r, 64'hC000_0000_0000_0000);
      do_op("lui", 1'b0, OP_LUI, 64'd0, 64'hABCDE, 0, r, dz, il, lat, rlow);
      check("lui_result", r, 64'hABCD_E000);

      // 5. Backpressure and illegal opcode.
      do_op("sub_hold", 1'b0, OP_SUB, 64'd10, 64'd3, 5, r, dz, il, lat, rlow);
      check("sub_hold_result", r, 64'd7);
      check("sub_hold_in_ready_low", 64'(rlow), 64'd6);
      do_op("illegal", 1'b0, 8'h20, 64'd1, 64'd2, 0, r, dz, il, lat, rlow);
      check("illegal_result", r, 64'd0);
      check("illegal_flag", 64'(il), 64'd1);
      check("illegal_latency", 64'(lat), 64'd1);

      // 6. Reset during a DIV iteration.
      @(negedge clk);
      opcode = OP_DIV; op1 = 64'd1000; op2 = 64'd3; out_ready = 1'b1; v64 = 1'b1;
      @(posedge clk);
      #1 v64 = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(ov64), 64'd0);
      check("midrst_in_ready", 64'(ir64), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (ov64) break;
      end
      check("midrst_no_stale_valid", 64'(ov64), 64'd0);
      check("midrst_release_in_ready", 64'(ir64), 64'd1);
      do_op("add_after_rst", 1'b0, OP_ADD, 64'd2, 64'd2, 0, r, dz, il, lat, rlow);
      check("add_after_rst_result", r, 64'd4);

      // Tests 1-3 at XLEN=32.
      do_op("add32", 1'b1, OP_ADD, 64'hFFFF_FFFF, 64'd1, 0, r, dz, il, lat, rlow);
      check("add32_result", r, 64'd0);
      check("add32_latency", 64'(lat), 64'd1);
      do_op("mul32", 1'b1, OP_MUL, 64'h1_0000_0003, 64'h5, 0, r, dz, il, lat, rlow);
      check("mul32_result", r, 64'hF);
      check("mul32_latency", 64'(lat), 64'd33);
      do_op("mul32b", 1'b1, OP_MUL, 64'h0001_2345, 64'h0000_1000, 0, r, dz, il, lat, rlow);
      check("mul32b_result", r, 64'h1234_5000);
      do_op("div32", 1'b1, OP_DIV, 64'd100, 64'd7, 0, r, dz, il, lat, rlow);
      check("div32_result", r, 64'd14);
      check("div32_latency", 64'(lat), 64'd33);
      do_op("rem32", 1'b1, OP_REM, 64'd100, 64'd7, 0, r, dz, il, lat, rlow);
      check("rem32_result", r, 64'd2);
      do_op("div32_0", 1'b1, OP_DIV, 64'd5, 64'd0, 0, r, dz, il, lat, rlow);
      check("div32_0_result", r, 64'hFFFF_FFFF);
      check("div32_0_flag", 64'(dz), 64'd1);
      check("div32_0_latency", 64'(lat), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
